// File: rtl/pm_loader.sv
// Program-memory loader: receives a framed byte stream, packs HI/LO byte pairs into 16-bit
// words written from address 0, and releases the CPU hold only after a matching checksum.
module pm_loader #(
  parameter int unsigned AddrW = 8,   // keep AddrW <= 15 so the word count fits the 16-bit length
  parameter int unsigned DataW = 16
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             start_i,
  input  logic             in_valid_i,
  input  logic [7:0]       in_data_i,
  output logic             in_ready_o,
  output logic             pm_we_o,
  output logic [AddrW-1:0] pm_addr_o,
  output logic [DataW-1:0] pm_wdata_o,
  output logic             cpu_hold_o,
  output logic             done_o,
  output logic             error_o,
  output logic [AddrW:0]   word_count_o
);

  typedef enum logic [2:0] {
    StIdle,
    StLenHi,
    StLenLo,
    StDataHi,
    StDataLo,
    StCheck,
    StDone,
    StError
  } state_e;

  localparam logic [16:0] MaxWords = 17'(2 ** AddrW);

  state_e           state_q;
  logic [15:0]      len_q;
  logic [7:0]       hi_q;
  logic [7:0]       csum_q;
  logic [AddrW:0]   word_count_q;
  logic             pm_we_q;
  logic [AddrW-1:0] pm_addr_q;
  logic [DataW-1:0] pm_wdata_q;
  logic             cpu_hold_q;
  logic             done_q;
  logic             error_q;

  logic        accept;
  logic [15:0] len_new;
  logic [15:0] count_next;
  logic        last_word;

  assign in_ready_o = state_q inside {StLenHi, StLenLo, StDataHi, StDataLo, StCheck};
  assign accept     = in_valid_i & in_ready_o;
  assign len_new    = {len_q[15:8], in_data_i};
  // The word being completed is number word_count_q + 1; it is the last one when that equals len.
  assign count_next = 16'(word_count_q) + 16'd1;
  assign last_word  = (count_next == len_q);

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q      <= StIdle;
      len_q        <= '0;
      hi_q         <= '0;
      csum_q       <= '0;
      word_count_q <= '0;
      pm_we_q      <= 1'b0;
      pm_addr_q    <= '0;
      pm_wdata_q   <= '0;
      cpu_hold_q   <= 1'b1;
      done_q       <= 1'b0;
      error_q      <= 1'b0;
    end else begin
      pm_we_q <= 1'b0;
      unique case (state_q)
        StIdle, StDone, StError: begin
          if (start_i) begin
            state_q      <= StLenHi;
            done_q       <= 1'b0;
            error_q      <= 1'b0;
            word_count_q <= '0;
            csum_q       <= '0;
            cpu_hold_q   <= 1'b1;
          end
        end
        StLenHi: begin
          if (accept) begin
            len_q[15:8] <= in_data_i;
            state_q     <= StLenLo;
          end
        end
        StLenLo: begin
          if (accept) begin
            len_q[7:0] <= in_data_i;
            if (len_new == 16'd0 || {1'b0, len_new} > MaxWords) begin
              state_q <= StError;
              error_q <= 1'b1;
            end else begin
              state_q <= StDataHi;
            end
          end
        end
        StDataHi: begin
          if (accept) begin
            hi_q    <= in_data_i;
            csum_q  <= csum_q + in_data_i;
            state_q <= StDataLo;
          end
        end
        StDataLo: begin
          if (accept) begin
            csum_q       <= csum_q + in_data_i;
            pm_we_q      <= 1'b1;
            pm_wdata_q   <= {hi_q, in_data_i};
            pm_addr_q    <= word_count_q[AddrW-1:0];
            word_count_q <= word_count_q + {{AddrW{1'b0}}, 1'b1};
            state_q      <= last_word ? StCheck : StDataHi;
          end
        end
        StCheck: begin
          if (accept) begin
            if (in_data_i == csum_q) begin
              state_q    <= StDone;
              done_q     <= 1'b1;
              cpu_hold_q <= 1'b0;
            end else begin
              state_q <= StError;
              error_q <= 1'b1;
            end
          end
        end
      endcase
    end
  end

  assign pm_we_o      = pm_we_q;
  assign pm_addr_o    = pm_addr_q;
  assign pm_wdata_o   = pm_wdata_q;
  assign cpu_hold_o   = cpu_hold_q;
  assign done_o       = done_q;
  assign error_o      = error_q;
  assign word_count_o = word_count_q;

endmodule

// File: tb/tb_pm_loader.sv
// Bench for pm_loader: frames are driven byte by byte, expected PM writes go to a scoreboard
// queue and are matched (address, data, cycle) when pm_we fires.
module tb_pm_loader;

  localparam int unsigned AddrW = 8;

  logic             clk = 1'b0;
  logic             rst_n;
  logic             start;
  logic             in_valid;
  logic [7:0]       in_data;
  logic             in_ready;
  logic             pm_we;
  logic [AddrW-1:0] pm_addr;
  logic [15:0]      pm_wdata;
  logic             cpu_hold;
  logic             done;
  logic             error;
  logic [AddrW:0]   word_count;

  pm_loader #(.AddrW(AddrW), .DataW(16)) dut (
    .clk_i       (clk),
    .rst_ni      (rst_n),
    .start_i     (start),
    .in_valid_i  (in_valid),
    .in_data_i   (in_data),
    .in_ready_o  (in_ready),
    .pm_we_o     (pm_we),
    .pm_addr_o   (pm_addr),
    .pm_wdata_o  (pm_wdata),
    .cpu_hold_o  (cpu_hold),
    .done_o      (done),
    .error_o     (error),
    .word_count_o(word_count)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [7:0]  addr;
    logic [15:0] data;
    int          at;
  } wr_t;

  wr_t        sb[$];
  wr_t        exp_wr;
  logic [7:0] frame[$];
  int         n_checks = 0;
  int         n_fail = 0;
  int         neg_cnt = 0;

  // Write monitor: every pm_we must match the oldest expected write, on the expected cycle.
  always @(negedge clk) begin
    if (pm_we === 1'b1) begin
      n_checks++;
      if (sb.size() == 0) begin
        n_fail++;
        $display("FAIL unexpected_write: got addr=%0h data=%0h, required no write",
                 pm_addr, pm_wdata);
      end else begin
        exp_wr = sb.pop_front();
        if (pm_addr !== exp_wr.addr || pm_wdata !== exp_wr.data || neg_cnt != exp_wr.at) begin
          n_fail++;
          $display("FAIL pm_write: got addr=%0h data=%0h cycle=%0d, required addr=%0h data=%0h cycle=%0d",
                   pm_addr, pm_wdata, neg_cnt, exp_wr.addr, exp_wr.data, exp_wr.at);
        end
      end
    end
    neg_cnt++;
  end

  task automatic send_byte(input logic [7:0] b, output bit ok);
    int guard = 0;
    bit rdy;
    in_valid = 1'b1;
    in_data  = b;
    do begin
      rdy = in_ready;
      @(posedge clk);
      #1;
      guard++;
    end while (!rdy && guard < 20);
    ok = rdy;
    n_checks++;
    if (!rdy) begin
      n_fail++;
      $display("FAIL handshake: byte %0h got in_ready=0 for 20 cycles, required 1", b);
    end
    in_valid = 1'b0;
  endtask

  // Drives frame[] after a start pulse; gap inserts an idle cycle between bytes and
  // start_at pulses start during the gap before that byte index.
  task automatic send_frame(input bit gap, input int start_at);
    logic [7:0] hi = 8'h00;
    int idx;
    bit ok;
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    for (int i = 0; i < frame.size(); i++) begin
      if (gap && i > 0) begin
        in_valid = 1'b0;
        start    = (i == start_at);
        @(posedge clk);
        #1;
        start = 1'b0;
      end
      send_byte(frame[i], ok);
      if (i >= 2 && i < frame.size() - 1) begin
        idx = i - 2;
        if (idx % 2 == 0) hi = frame[i];
        else if (ok) sb.push_back('{addr: 8'(idx / 2), data: {hi, frame[i]}, at: neg_cnt});
      end
    end
    @(posedge clk);
    #1;
    n_checks++;
    if (sb.size() != 0) begin
      n_fail++;
      $display("FAIL missing_writes: got %0d writes outstanding, required 0", sb.size());
      sb.delete();
    end
  endtask

  task automatic load_case2(input logic [7:0] csum);
    frame = '{8'h00, 8'h02, 8'h12, 8'h34, 8'hAB, 8'hCD, csum};
  endtask

  task automatic test_reset;
    rst_n    = 1'b0;
    start    = 1'b0;
    in_valid = 1'b0;
    in_data  = 8'h00;
    repeat (3) @(posedge clk);
    #1;
    n_checks++;
    if ({cpu_hold, in_ready, pm_we, done, error} !== 5'b10000) begin
      n_fail++;
      $display("FAIL reset_flags: got hold/rdy/we/done/err=%b, required 10000",
               {cpu_hold, in_ready, pm_we, done, error});
    end
    n_checks++;
    if (word_count !== 9'd0 || pm_addr !== 8'd0 || pm_wdata !== 16'd0) begin
      n_fail++;
      $display("FAIL reset_regs: got wc=%0d addr=%0h data=%0h, required 0 0 0",
               word_count, pm_addr, pm_wdata);
    end
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
  endtask

  task automatic test_good_load;
    load_case2(8'hBE);
    send_frame(1'b0, -1);
    n_checks++;
    if ({done, error, cpu_hold, in_ready} !== 4'b1000 || word_count !== 9'd2) begin
      n_fail++;
      $display("FAIL good_load: got done/err/hold/rdy=%b wc=%0d, required 1000 wc=2",
               {done, error, cpu_hold, in_ready}, word_count);
    end
    n_checks++;
    if (pm_addr !== 8'd1 || pm_we !== 1'b0) begin
      n_fail++;
      $display("FAIL addr_hold: got addr=%0h we=%b, required addr=1 we=0", pm_addr, pm_we);
    end
  endtask

  task automatic test_bad_csum;
    load_case2(8'hBF);
    send_frame(1'b0, -1);
    n_checks++;
    if ({done, error, cpu_hold} !== 3'b011 || word_count !== 9'd2) begin
      n_fail++;
      $display("FAIL bad_csum: got done/err/hold=%b wc=%0d, required 011 wc=2",
               {done, error, cpu_hold}, word_count);
    end
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    n_checks++;
    if ({error, in_ready, cpu_hold} !== 3'b011 || word_count !== 9'd0) begin
      n_fail++;
      $display("FAIL restart_clear: got err/rdy/hold=%b wc=%0d, required 011 wc=0",
               {error, in_ready, cpu_hold}, word_count);
    end
  endtask

  task automatic test_bad_length;
    frame = '{8'h00, 8'h00};
    send_frame(1'b0, -1);
    n_checks++;
    if ({error, done, in_ready, cpu_hold} !== 4'b1001 || word_count !== 9'd0) begin
      n_fail++;
      $display("FAIL len_zero: got err/done/rdy/hold=%b wc=%0d, required 1001 wc=0",
               {error, done, in_ready, cpu_hold}, word_count);
    end
    frame = '{8'h01, 8'h01};
    send_frame(1'b0, -1);
    n_checks++;
    if ({error, done, in_ready} !== 3'b100) begin
      n_fail++;
      $display("FAIL len_257: got err/done/rdy=%b, required 100", {error, done, in_ready});
    end
  endtask

  task automatic test_max_length;
    logic [7:0] csum = 8'h00;
    logic [7:0] hb;
    logic [7:0] lb;
    frame = '{8'h01, 8'h00};
    for (int i = 0; i < 256; i++) begin
      hb = 8'(i) ^ 8'h5A;
      lb = 8'(i * 3);
      frame.push_back(hb);
      frame.push_back(lb);
      csum = csum + hb + lb;
    end
    frame.push_back(csum);
    send_frame(1'b0, -1);
    n_checks++;
    if ({done, error, cpu_hold} !== 3'b100 || word_count !== 9'd256 || pm_addr !== 8'hFF) begin
      n_fail++;
      $display("FAIL max_len: got done/err/hold=%b wc=%0d addr=%0h, required 100 wc=256 addr=ff",
               {done, error, cpu_hold}, word_count, pm_addr);
    end
  endtask

  task automatic test_gapped_with_start;
    load_case2(8'hBE);
    send_frame(1'b1, 3);
    n_checks++;
    if ({done, error, cpu_hold} !== 3'b100 || word_count !== 9'd2) begin
      n_fail++;
      $display("FAIL gapped: got done/err/hold=%b wc=%0d, required 100 wc=2",
               {done, error, cpu_hold}, word_count);
    end
  endtask

  task automatic test_reset_midload;
    bit ok;
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    send_byte(8'h00, ok);
    send_byte(8'h02, ok);
    send_byte(8'h12, ok);
    #2;
    rst_n = 1'b0;
    #1;
    n_checks++;
    if ({cpu_hold, in_ready, pm_we, done, error} !== 5'b10000 || word_count !== 9'd0 ||
        pm_addr !== 8'd0 || pm_wdata !== 16'd0) begin
      n_fail++;
      $display("FAIL midload_reset: got flags=%b wc=%0d addr=%0h data=%0h, required 10000 0 0 0",
               {cpu_hold, in_ready, pm_we, done, error}, word_count, pm_addr, pm_wdata);
    end
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    load_case2(8'hBE);
    send_frame(1'b0, -1);
    n_checks++;
    if ({done, error, cpu_hold} !== 3'b100 || word_count !== 9'd2) begin
      n_fail++;
      $display("FAIL reload: got done/err/hold=%b wc=%0d, required 100 wc=2",
               {done, error, cpu_hold}, word_count);
    end
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached, required completion");
    $fatal(1);
  end

  initial begin
    test_reset();
    test_good_load();
    test_bad_csum();
    test_bad_length();
    test_max_length();
    test_gapped_with_start();
    test_reset_midload();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
